// File: rtl/const_sizes_pkg.sv
// Shared constants for the 64-bit constant-word interface: golden table,
// word type and the checker FSM state encoding.
package const_sizes_pkg;

  localparam int NUM_CONST_WORDS = 9;

  typedef logic [63:0] word_t;

  // Golden word for each frame position, word 0 first.
  localparam word_t GOLDEN [NUM_CONST_WORDS] = '{
    64'd7698294523898761276,
    64'd7698294523898761276,
    64'hADB52ACAAAAAAAAE,
    64'hACBF74CFA4B5A09B,
    64'd2147483528,
    64'd4273735593,
    64'd8547471186,
    64'h4000000000000000,
    64'd18446612958979913719
  };

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, REPORT} state_t;

endpackage

// File: rtl/word_deserializer.sv
// Rebuilds a 64-bit word from CHUNK_W-wide chunks arriving least-significant
// chunk first. Each accepted chunk enters at the top of the shift register, so
// after 64/CHUNK_W chunks the first one has reached bit 0.
module word_deserializer
  import const_sizes_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [CHUNK_W-1:0] chunk,
  output word_t              word,
  output logic               word_valid
);

  localparam int CHUNKS = 64 / CHUNK_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  word_t            word_q, word_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A 64-bit chunk is the whole word; narrower chunks shift in from the top.
  if (CHUNK_W == 64) begin : g_full
    assign shifted = word_t'(chunk);
  end else begin : g_shift
    assign shifted = {chunk, word_q[63:CHUNK_W]};
  end

  // Shift on every accepted chunk; the counter wraps after the last chunk of a word.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (shift_en) begin
      word_d = shifted;
      cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = shift_en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/const_word_checker.sv
// Receives a frame of NUM_WORDS 64-bit words as a chunk stream, compares each
// reassembled word against its golden constant and reports per-word mismatch
// flags plus an overall pass result.
module const_word_checker
  import const_sizes_pkg::*;
#(
  parameter  int CHUNK_W   = 16,
  parameter  int NUM_WORDS = 9,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHUNK_W-1:0]   in_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_WORDS-1:0] mismatch_mask,
  output logic [IDX_W-1:0]     word_idx
);

  if (!(CHUNK_W == 8 || CHUNK_W == 16 || CHUNK_W == 32 || CHUNK_W == 64)) begin : g_bad_chunk_w
    $error("const_word_checker: CHUNK_W must be 8, 16, 32 or 64");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > NUM_CONST_WORDS) begin : g_bad_num_words
    $error("const_word_checker: NUM_WORDS exceeds golden table depth");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  logic                 pass_q, pass_d;
  logic                 deser_clear;
  logic                 handshake;
  logic                 word_valid;
  word_t                assembled;

  // Abort discards any chunk offered in the same cycle.
  assign handshake = in_valid && in_ready && !abort;

  word_deserializer #(
    .CHUNK_W (CHUNK_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .clear      (deser_clear),
    .shift_en   (handshake),
    .chunk      (in_data),
    .word       (assembled),
    .word_valid (word_valid)
  );

  // Next-state logic: frame sequencing, per-word compare and pass evaluation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    pass_d      = pass_q;
    deser_clear = 1'b0;
    if (abort) begin
      // Partial mask is kept for inspection; the frame did not pass.
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = COLLECT;
            idx_d       = '0;
            mask_d      = '0;
            pass_d      = 1'b0;
            deser_clear = 1'b1;
          end
        end
        COLLECT: begin
          if (word_valid) state_d = COMPARE;
        end
        COMPARE: begin
          mask_d[idx_q] = (assembled != GOLDEN[idx_q]);
          if (idx_q == LAST_IDX) begin
            state_d = REPORT;
            // Registered here so pass is valid in the same cycle as done.
            pass_d  = ~|mask_d;
          end else begin
            state_d = COLLECT;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        REPORT: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  assign in_ready      = (state_q == COLLECT);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == REPORT) && !abort;
  assign pass          = pass_q;
  assign mismatch_mask = mask_q;
  assign word_idx      = idx_q;

endmodule
